// File: rtl/sys_rst_seq_if.sv
// Control/status bundle of the reset sequencer: lock and software restart in,
// per-domain resets and sequence status out.
interface sys_rst_seq_if #(
  parameter int unsigned NUM_RST = 4
);
  logic               lock_in;
  logic               sw_rst_req;
  logic [NUM_RST-1:0] rst_out;
  logic               seq_done;
  logic [1:0]         state_o;

  modport master (
    input  lock_in,
    input  sw_rst_req,
    output rst_out,
    output seq_done,
    output state_o
  );

  modport slave (
    output lock_in,
    output sw_rst_req,
    input  rst_out,
    input  seq_done,
    input  state_o
  );
endinterface

// File: rtl/sys_rst_seq.sv
// Reset sequencer: filters PLL lock, then releases NUM_RST domain resets one
// at a time, lowest index first; any lock loss or software request restarts.
module sys_rst_seq #(
  parameter int unsigned NUM_RST     = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned STEP_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  sys_rst_seq_if.master seq_if
);

  localparam int unsigned MAX_HL  = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
  localparam int unsigned MAX_CNT = (MAX_HL > STEP_CYCLES) ? MAX_HL : STEP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
  localparam int unsigned IW      = $clog2(NUM_RST) + 1;

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_LOCK_WAIT = 2'd1,
    S_RELEASE   = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      idx_q;
  logic [NUM_RST-1:0] rst_out_q;
  logic               seq_done_q;
  logic               sync1_q;
  logic               lock_s_q;
  logic               abort_c;

  // Two-flop synchronizer for the free-running PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= seq_if.lock_in;
      lock_s_q <= sync1_q;
    end
  end

  // Lock loss only matters once domains have started to come out of reset.
  assign abort_c = seq_if.sw_rst_req |
                   (~lock_s_q & ((state_q == S_RELEASE) | (state_q == S_DONE)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
    end else if (abort_c) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_q <= S_LOCK_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_LOCK_WAIT: begin
          if (!lock_s_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
            state_q <= S_RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == CW'(STEP_CYCLES - 1)) begin
            rst_out_q <= rst_out_q & ~(NUM_RST'(1) << idx_q);
            idx_q     <= idx_q + IW'(1);
            cnt_q     <= '0;
            if (idx_q == IW'(NUM_RST - 1)) begin
              state_q    <= S_DONE;
              seq_done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          seq_done_q <= 1'b1;
        end
        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign seq_if.rst_out  = rst_out_q;
  assign seq_if.seq_done = seq_done_q;
  assign seq_if.state_o  = state_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Self-checking bench for sys_rst_seq: event-time reference model for the
// default configuration plus a fixed-table check of the minimal configuration.
module tb_sys_rst_seq;

  localparam int NR = 4;
  localparam int HC = 4;
  localparam int LF = 16;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sys_rst_seq_if #(.NUM_RST(NR)) a_if ();
  sys_rst_seq_if #(.NUM_RST(1))  b_if ();

  sys_rst_seq #(.NUM_RST(NR), .HOLD_CYCLES(HC), .LOCK_FILTER(LF), .STEP_CYCLES(SC)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .seq_if (a_if.master)
  );

  sys_rst_seq #(.NUM_RST(1), .HOLD_CYCLES(1), .LOCK_FILTER(1), .STEP_CYCLES(1)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .seq_if (b_if.master)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Model: edge count since reset, edge of last (re)start, edge at which
  // RELEASE was entered (-1 if not yet), current lock-high run in LOCK_WAIT.
  int m_n, m_r, m_e, m_run;
  bit lk_q[$];

  logic [NR+2:0] obs;
  logic [NR+2:0] expv;

  function automatic logic [NR+2:0] model_out();
    logic [NR-1:0] r;
    int rel;
    if (m_e < 0) return {{NR{1'b1}}, 1'b0, (m_n < m_r + HC) ? 2'd0 : 2'd1};
    rel = (m_n - m_e) / SC;
    if (rel > NR) rel = NR;
    r = '1;
    for (int i = 0; i < rel; i++) r[i] = 1'b0;
    return {r, (rel == NR), (rel == NR) ? 2'd3 : 2'd2};
  endfunction

  task automatic model_reset();
    m_n = 0; m_r = 0; m_e = -1; m_run = 0;
    lk_q.delete();
  endtask

  task automatic model_edge(input bit lin, input bit sw);
    bit ls;
    m_n++;
    ls = (lk_q.size() >= 2) ? lk_q[lk_q.size()-2] : 1'b0;
    lk_q.push_back(lin);
    if (lk_q.size() > 4) void'(lk_q.pop_front());
    if (sw || (m_e >= 0 && m_n > m_e && !ls)) begin
      m_r = m_n; m_e = -1; m_run = 0;
    end else if (m_e < 0 && m_n > m_r + HC) begin
      m_run = ls ? m_run + 1 : 0;
      if (m_run == LF) m_e = m_n;
    end
  endtask

  // One clock edge: inputs sampled, model advanced, return at the falling edge.
  task automatic tick();
    bit lin, sw;
    lin = a_if.lock_in;
    sw  = a_if.sw_rst_req;
    @(posedge clk);
    model_edge(lin, sw);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    obs = {a_if.rst_out, a_if.seq_done, a_if.state_o};
    n_chk++;
    if (obs !== {4'b1111, 1'b0, 2'd0}) $display("FAIL reset_a: got %b want %b", obs, {4'b1111, 1'b0, 2'd0});
    else n_pass++;
    n_chk++;
    if ({b_if.rst_out, b_if.seq_done, b_if.state_o} !== 4'b1000)
      $display("FAIL reset_b: got %b want 1000", {b_if.rst_out, b_if.seq_done, b_if.state_o});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 60; i++) begin
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL nominal edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
      if (m_n == 27 || m_n == 28 || m_n == 52) begin
        n_chk++;
        if (obs !== ((m_n == 27) ? {4'b1111, 1'b0, 2'd2} :
                     (m_n == 28) ? {4'b1110, 1'b0, 2'd2} : {4'b0000, 1'b1, 2'd3}))
          $display("FAIL nominal_timing edge %0d: got %b", m_n, obs);
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      a_if.lock_in = (m_n == 14) ? 1'b0 : 1'b1;
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL glitch edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
      if (m_n == 40 || m_n == 41) begin
        n_chk++;
        if (a_if.rst_out !== ((m_n == 40) ? 4'b1111 : 4'b1110))
          $display("FAIL glitch_delay edge %0d: got %b", m_n, a_if.rst_out);
        else n_pass++;
      end
    end
    a_if.lock_in = 1'b1;
  endtask

  task automatic test_lock_loss();
    apply_reset();
    for (int i = 0; i < 36; i++) begin
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL lockloss_pre edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
    end
    n_chk++;
    if (a_if.rst_out !== 4'b1100) $display("FAIL lockloss_start: got %b want 1100", a_if.rst_out);
    else n_pass++;
    a_if.lock_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL lockloss edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
    end
    n_chk++;
    if (obs !== {4'b1111, 1'b0, 2'd0}) $display("FAIL lockloss_3edge: got %b want 1111000", obs);
    else n_pass++;
    a_if.lock_in = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL relock edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
    end
    n_chk++;
    if (a_if.seq_done !== 1'b1) $display("FAIL relock_done: got %b want 1", a_if.seq_done);
    else n_pass++;
  endtask

  task automatic test_sw_req();
    a_if.sw_rst_req = 1'b1;
    tick();
    a_if.sw_rst_req = 1'b0;
    obs = {a_if.rst_out, a_if.seq_done, a_if.state_o};
    n_chk++;
    if (obs !== {4'b1111, 1'b0, 2'd0}) $display("FAIL sw_abort: got %b want 1111000", obs);
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL sw_reseq edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
    end
    n_chk++;
    if (a_if.seq_done !== 1'b1) $display("FAIL sw_reseq_done: got %b want 1", a_if.seq_done);
    else n_pass++;
  endtask

  task automatic test_async_rst();
    bit reached;
    reached = 1'b0;
    a_if.sw_rst_req = 1'b1;
    tick();
    a_if.sw_rst_req = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL async_pre edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
      if (expv[NR+2:3] == 4'b1100) reached = 1'b1;
    end
    n_chk++;
    if (!reached || a_if.rst_out !== 4'b1100) $display("FAIL async_setup: got %b want 1100", a_if.rst_out);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    obs = {a_if.rst_out, a_if.seq_done, a_if.state_o};
    n_chk++;
    if (obs !== {4'b1111, 1'b0, 2'd0}) $display("FAIL async_rst: got %b want 1111000", obs);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL async_post edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      a_if.lock_in    = ($urandom_range(0, 149) != 0);
      a_if.sw_rst_req = ($urandom_range(0, 399) == 0);
      tick();
      obs = {a_if.rst_out, a_if.seq_done, a_if.state_o}; expv = model_out();
      n_chk++;
      if (obs !== expv) $display("FAIL random edge %0d: got %b want %b", m_n, obs, expv);
      else n_pass++;
    end
    a_if.lock_in    = 1'b1;
    a_if.sw_rst_req = 1'b0;
  endtask

  task automatic test_min_cfg();
    bit       lk [14] = '{1,1,1,1,1,1,1,1,1,0,0,0,0,0};
    bit       sw [14] = '{0,0,0,0,0,1,0,0,0,0,0,0,0,0};
    logic [3:0] ex [14] = '{4'b1001, 4'b1001, 4'b1010, 4'b0111, 4'b0111,
                            4'b1000, 4'b1001, 4'b1010, 4'b0111,
                            4'b0111, 4'b0111, 4'b1000, 4'b1001, 4'b1001};
    logic [3:0] ob;
    b_if.lock_in = 1'b1;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      b_if.lock_in    = lk[i];
      b_if.sw_rst_req = sw[i];
      tick();
      ob = {b_if.rst_out, b_if.seq_done, b_if.state_o};
      n_chk++;
      if (ob !== ex[i]) $display("FAIL min_cfg step %0d: got %b want %b", i, ob, ex[i]);
      else n_pass++;
    end
    b_if.sw_rst_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    a_if.lock_in    = 1'b1;
    a_if.sw_rst_req = 1'b0;
    b_if.lock_in    = 1'b0;
    b_if.sw_rst_req = 1'b0;
    model_reset();
    test_reset();
    test_nominal();
    test_glitch();
    test_lock_loss();
    test_sw_req();
    test_async_rst();
    test_random();
    test_min_cfg();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sys_rst_seq.md
# sys_rst_seq

Synthesizable reset sequencer that owns release of the per-domain resets behind the system clock source. Waits for a PLL/MMCM lock indication and filters it for a programmable stable time. Then deasserts NUM_RST domain resets one at a time, lowest index first, at a fixed spacing. Any lock loss or software reset request re-asserts every domain reset and restarts the sequence. Sits at the top of the core next to the clock source and drives the reset inputs of every downstream clock-domain block.

## Interface
- NUM_RST, 4: number of sequenced domain resets (>=1)
- HOLD_CYCLES, 4: minimum cycles all resets stay asserted after any (re)start (>=1)
- LOCK_FILTER, 16: consecutive synchronized-lock-high cycles required before release (>=1)
- STEP_CYCLES, 8: cycles between successive domain releases (>=1)
- clk  in  1  system clock; sole clock of the block
- rst  in  1  asynchronous, active-high reset
- lock_in  in  1  raw PLL lock, asynchronous to clk
- sw_rst_req  in  1  synchronous single-cycle software restart request
- rst_out  out  NUM_RST  active-high domain resets; bit k released k-th
- seq_done  out  1  high while all domain resets are released
- state_o  out  2  current state: 0 HOLD, 1 LOCK_WAIT, 2 RELEASE, 3 DONE

## Operation
- lock_in passes through a 2-flop synchronizer (both flops reset to 0) to give lock_s; only lock_s is used internally.
- One shared counter cnt, width clog2(max(HOLD_CYCLES, LOCK_FILTER, STEP_CYCLES)) + 1; release index idx, width clog2(NUM_RST) + 1.
- HOLD: rst_out all 1, seq_done 0, cnt increments. When cnt == HOLD_CYCLES-1, go to LOCK_WAIT with cnt cleared.
- LOCK_WAIT: cnt increments while lock_s = 1 and clears when lock_s = 0. When cnt == LOCK_FILTER-1 and lock_s = 1, go to RELEASE with cnt and idx cleared.
- RELEASE: cnt increments each cycle. When cnt == STEP_CYCLES-1, clear rst_out[idx], increment idx and clear cnt. When the released bit is NUM_RST-1, go to DONE on the same edge and set seq_done.
- DONE: rst_out all 0, seq_done 1; hold until an abort.
- Abort: lock_s = 0 in RELEASE or DONE, or sw_rst_req = 1 in any state. Next edge: rst_out all 1, seq_done 0, cnt 0, state HOLD.
  - sw_rst_req in HOLD restarts the hold count.
  - Simultaneous lock loss and sw_rst_req give a single abort with identical behaviour.
- Released bits never re-assert individually; the only re-assert path is an abort, which asserts all bits.

## Timing
- Async reset values:
  - rst_out all 1, seq_done 0, state_o 0 (HOLD)
  - cnt 0, idx 0, synchronizer flops 0
- All outputs are registered; no combinational path from any input to any output.
- lock_in to lock_s latency: 2 clk edges.
- Time counted from the first LOCK_WAIT cycle with lock_s continuously high:
  - RELEASE entered after LOCK_FILTER edges.
  - rst_out[k] falls STEP_CYCLES*(k+1) edges after entering RELEASE.
  - seq_done rises on the same edge as rst_out[NUM_RST-1] falls.
- Abort latency: 1 edge from the cycle lock_s = 0 or sw_rst_req = 1 is sampled. From lock_in falling, 3 edges worst case.
- Minimum restart gap: after an abort, rst_out stays all-1 for at least HOLD_CYCLES + LOCK_FILTER + STEP_CYCLES cycles.
- rst asserted mid-sequence: immediate (asynchronous) return to the reset values above. Deassertion is synchronous to clk.

## Test plan
- Defaults, lock_in held 1 from time 0, rst released at edge 0:
  - HOLD for edges 1-4, LOCK_WAIT from edge 5.
  - rst_out 1111 -> 1110 -> 1100 -> 1000 -> 0000 at 8-cycle spacing.
  - seq_done rises with the last release; state_o goes 0, 1, 2, 3.
- lock_in glitches low for 1 cycle after 10 lock-high cycles in LOCK_WAIT -> filter count restarts; RELEASE is delayed by 11 + 2 cycles; rst_out stays 1111 throughout.
- lock_in drops while rst_out = 1100 -> 3 edges later rst_out = 1111, state_o = 0, seq_done = 0. Relock repeats the full sequence.
- sw_rst_req pulse in DONE -> next edge rst_out = 1111, seq_done = 0. Full re-sequence follows.
- rst asserted while in RELEASE with idx = 2 -> rst_out = 1111 immediately, without a clk edge; restart from HOLD after deassertion.
- NUM_RST = 1, STEP_CYCLES = 1, LOCK_FILTER = 1, HOLD_CYCLES = 1 -> rst_out[0] falls exactly 1 edge after RELEASE entry, with seq_done rising on the same edge.
